alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Driving side of the 4-op ALU interface (Rs_data/Rt_data/sharmt/Funct in, Rd_data/Zero out).
//  Accepts one R-type instruction word per valid/ready handshake and decodes it.
//  Reads a 32-entry register file, drives the ALU, and writes the result back.
//  Serial, single-issue: one instruction in flight; ALU is instantiated outside, beside this block.
// PARAMETERS
//  DATA_W    32   register and ALU operand width
//  NUM_REGS  32   register file entries; address width fixed at 5 bits
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  instr_valid  in   1   instr holds a valid instruction
//  instr_ready  out  1   unit can accept an instruction this cycle
//  instr        in   32  op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
//  alu_rs_data  out  32  ALU operand A (registered)
//  alu_rt_data  out  32  ALU operand B (registered)
//  alu_sharmt   out  5   ALU shift amount (registered)
//  alu_funct    out  2   ALU op: 0 add, 1 sub, 2 shift-left, 3 or (registered)
//  alu_rd_data  in   32  ALU result (combinational from the outputs above)
//  alu_zero     in   1   ALU result==0
//  done         out  1   one-cycle pulse: instruction retired (legal or illegal)
//  illegal      out  1   valid with done: instruction rejected, no writeback
//  result       out  32  last retired ALU result; holds until next retire
//  zero_flag    out  1   alu_zero captured with result
//  dbg_addr     in   5   debug read address
//  dbg_data     out  32  regfile[dbg_addr], combinational; 0 for address 0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; all regfile entries=0; alu_* outputs=0;
//   done=0, illegal=0, result=0, zero_flag=0. Reset beats any in-flight op; that op is discarded with no writeback.
//  instr_ready = (state==IDLE) && rst_n. Handshake fires at an edge with instr_valid && instr_ready.
//  FSM: IDLE -> DECODE (on handshake; instr latched) -> EXEC -> WB -> IDLE.
//  DECODE: legal iff op==0 and funct in {0x20 add->0, 0x22 sub->1, 0x00 sll->2, 0x25 or->3}.
//   Legal: latch regfile[rs], regfile[rt], shamt and mapped Funct into alu_* regs; next state EXEC.
//   Illegal: next state IDLE; done=1 and illegal=1 for the one cycle after DECODE.
//   alu_* registers are unchanged; result and regfile are unchanged.
//  EXEC: alu_* stable for the whole cycle; at its end, capture alu_rd_data->result and alu_zero->zero_flag.
//  WB: done=1 and illegal=0; regfile[rd]<=result at the end of WB unless rd==0.
//  Latency: handshake at edge T -> done high in cycle T+3; instr_ready high again in cycle T+4.
//   Minimum issue interval is 4 cycles.
//  Register 0 reads as 0 and is never written; reads in DECODE see all prior writebacks (serial, no hazards).
//  Arithmetic: modulo 2^DATA_W; sub wraps, no overflow flag; sll uses shamt only and ignores rt.
//  alu_* outputs hold their last values while in IDLE.
//  instr is sampled only at the handshake edge; changes to instr while busy are ignored.
// TESTING
//  1 Reset, then dbg_addr sweep 0..31 -> dbg_data==0 for every entry; instr_ready=1 in the first cycle after reset.
//  2 Preload r1=5, r2=7 via add from r0 (seeded by a bench backdoor), then add r3,r1,r2 ->
//    alu_funct=0; done at T+3; result=12; zero_flag=0; dbg r3=12.
//  3 sub r4,r1,r1 -> result=0, zero_flag=1.
//    sub with r1=0, r2=1 -> result=0xFFFFFFFF (wrap).
//  4 sll r5,r2,shamt=31 with r2=1 -> alu_sharmt=31, result=0x80000000.
//    add with rd=0 -> done pulses, r0 stays 0.
//  5 funct=0x18 or op!=0 -> done=1 and illegal=1 one cycle after DECODE; regfile unchanged; next instr accepted.
//  6 rst_n=0 while in EXEC -> next cycle IDLE, outputs zero, no writeback;
//    instr_valid held high while busy -> only one handshake per 4 cycles.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Serial single-issue front end for an external 4-op ALU: accepts R-type words,
// reads a 32-entry register file, drives the ALU and writes the result back.
module alu_issue_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_rs_data,
  output logic [DATA_W-1:0] alu_rt_data,
  output logic [4:0]        alu_sharmt,
  output logic [1:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_rd_data,
  input  logic              alu_zero,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic       w_hs;
  logic       w_legal;
  logic [1:0] w_funct_code;
  logic       w_ld_ops;
  logic       w_cap_res;
  logic       w_wr_en;
  logic       w_done_nxt;
  logic       w_illegal_nxt;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;

  // Returns {legal, alu_code}; only op==0 with one of four functs is accepted.
  function automatic logic [2:0] decode_funct(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] d;
    d = 3'b000;
    if (op == 6'd0) begin
      case (fn)
        6'h20:   d = 3'b100;
        6'h22:   d = 3'b101;
        6'h00:   d = 3'b110;
        6'h25:   d = 3'b111;
        default: d = 3'b000;
      endcase
    end
    return d;
  endfunction

  assign w_rs = r_instr[25:21];
  assign w_rt = r_instr[20:16];
  assign w_rd = r_instr[15:11];
  assign {w_legal, w_funct_code} = decode_funct(r_instr[31:26], r_instr[5:0]);

  assign instr_ready = (r_state == S_IDLE) && rst_n;
  assign w_hs        = instr_valid && instr_ready;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_IDLE;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_ops      = (r_state == S_DECODE) && w_legal;
    w_illegal_nxt = (r_state == S_DECODE) && !w_legal;
    w_cap_res     = (r_state == S_EXEC);
    w_wr_en       = (r_state == S_WB) && (w_rd != 5'd0);
    // done is registered, so it rises in WB for legal ops and right after DECODE for rejects
    w_done_nxt    = w_cap_res || w_illegal_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr     <= '0;
      alu_rs_data <= '0;
      alu_rt_data <= '0;
      alu_sharmt  <= '0;
      alu_funct   <= '0;
      result      <= '0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_hs) r_instr <= instr;
      if (w_ld_ops) begin
        alu_rs_data <= (w_rs == 5'd0) ? '0 : r_regs[w_rs];
        alu_rt_data <= (w_rt == 5'd0) ? '0 : r_regs[w_rt];
        alu_sharmt  <= r_instr[10:6];
        alu_funct   <= w_funct_code;
      end
      if (w_cap_res) begin
        result    <= alu_rd_data;
        zero_flag <= alu_zero;
      end
      if (w_wr_en) r_regs[w_rd] <= result;
      done    <= w_done_nxt;
      illegal <= w_illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU beside the DUT, vector table plus
// scoreboard queue, and hand sequences for reset-in-flight and back-to-back valid.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_rs_data;
  logic [31:0] alu_rt_data;
  logic [4:0]  alu_sharmt;
  logic [1:0]  alu_funct;
  logic [31:0] alu_rd_data;
  logic        alu_zero;
  logic        done;
  logic        illegal;
  logic [31:0] result;
  logic        zero_flag;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        ovr_en;
  logic [31:0] ovr_val;
  logic [31:0] calc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic        ovr;
    logic [31:0] ovr_val;
    logic        ill;
    logic [31:0] res;
    logic        zf;
    logic [1:0]  fn;
    logic [4:0]  sh;
  } vec_t;

  vec_t        tbl [12];
  vec_t        exp_q [$];
  logic [31:0] mdl [32];

  alu_issue_unit #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_rs_data(alu_rs_data), .alu_rt_data(alu_rt_data),
    .alu_sharmt(alu_sharmt), .alu_funct(alu_funct), .alu_rd_data(alu_rd_data),
    .alu_zero(alu_zero), .done(done), .illegal(illegal), .result(result),
    .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU; the override path is the backdoor used to seed registers.
  always_comb begin
    calc = '0;
    case (alu_funct)
      2'd0:    calc = alu_rs_data + alu_rt_data;
      2'd1:    calc = alu_rs_data - alu_rt_data;
      2'd2:    calc = alu_rs_data << alu_sharmt;
      default: calc = alu_rs_data | alu_rt_data;
    endcase
    alu_rd_data = ovr_en ? ovr_val : calc;
    alu_zero    = (alu_rd_data == 32'd0);
  end

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic ovr, input logic [31:0] ov,
                              input logic ill, input logic [31:0] res, input logic zf,
                              input logic [1:0] fn, input logic [4:0] sh);
    vec_t v;
    v.ins = ins; v.ovr = ovr; v.ovr_val = ov; v.ill = ill;
    v.res = res; v.zf = zf; v.fn = fn; v.sh = sh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   lat;
    logic got;
    logic [4:0] rd;
    exp_q.push_back(v);
    @(negedge clk);
    instr = v.ins; instr_valid = 1'b1; ovr_en = v.ovr; ovr_val = v.ovr_val;
    chk($sformatf("v%0d_ready_pre", idx), {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), lat, e.ill ? 32'd2 : 32'd3);
      chk($sformatf("v%0d_illegal", idx), {31'd0, illegal}, {31'd0, e.ill});
      chk($sformatf("v%0d_result", idx), result, e.res);
      chk($sformatf("v%0d_zero", idx), {31'd0, zero_flag}, {31'd0, e.zf});
      chk($sformatf("v%0d_funct", idx), {30'd0, alu_funct}, {30'd0, e.fn});
      chk($sformatf("v%0d_sharmt", idx), {27'd0, alu_sharmt}, {27'd0, e.sh});
      chk($sformatf("v%0d_ready_at_done", idx), {31'd0, instr_ready}, {31'd0, e.ill});
    end
    ovr_en = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
    rd = e.ins[15:11];
    if (!e.ill && rd != 5'd0) mdl[rd] = e.res;
    dbg_addr = rd;
    #1;
    chk($sformatf("v%0d_dbg_rd", idx), dbg_data, mdl[rd]);
  endtask

  initial begin
    int hs;
    int dn;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    ovr_en = 1'b0; ovr_val = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    tbl[0]  = mk(rtype(6'd0, 5'd0, 5'd0, 5'd1,  5'd0,  6'h20), 1'b1, 32'd5, 1'b0, 32'd5,        1'b0, 2'd0, 5'd0);
    tbl[1]  = mk(rtype(6'd0, 5'd0, 5'd0, 5'd2,  5'd0,  6'h20), 1'b1, 32'd7, 1'b0, 32'd7,        1'b0, 2'd0, 5'd0);
    tbl[2]  = mk(rtype(6'd0, 5'd1, 5'd2, 5'd3,  5'd0,  6'h20), 1'b0, 32'd0, 1'b0, 32'd12,       1'b0, 2'd0, 5'd0);
    tbl[3]  = mk(rtype(6'd0, 5'd1, 5'd1, 5'd4,  5'd0,  6'h22), 1'b0, 32'd0, 1'b0, 32'd0,        1'b1, 2'd1, 5'd0);
    tbl[4]  = mk(rtype(6'd0, 5'd0, 5'd0, 5'd7,  5'd0,  6'h20), 1'b1, 32'd1, 1'b0, 32'd1,        1'b0, 2'd0, 5'd0);
    tbl[5]  = mk(rtype(6'd0, 5'd0, 5'd7, 5'd8,  5'd0,  6'h22), 1'b0, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 2'd1, 5'd0);
    tbl[6]  = mk(rtype(6'd0, 5'd7, 5'd3, 5'd5,  5'd31, 6'h00), 1'b0, 32'd0, 1'b0, 32'h80000000, 1'b0, 2'd2, 5'd31);
    tbl[7]  = mk(rtype(6'd0, 5'd1, 5'd2, 5'd0,  5'd0,  6'h20), 1'b0, 32'd0, 1'b0, 32'd12,       1'b0, 2'd0, 5'd0);
    tbl[8]  = mk(rtype(6'd0, 5'd1, 5'd2, 5'd9,  5'd0,  6'h18), 1'b0, 32'd0, 1'b1, 32'd12,       1'b0, 2'd0, 5'd0);
    tbl[9]  = mk(rtype(6'd8, 5'd1, 5'd2, 5'd10, 5'd0,  6'h20), 1'b0, 32'd0, 1'b1, 32'd12,       1'b0, 2'd0, 5'd0);
    tbl[10] = mk(rtype(6'd0, 5'd1, 5'd2, 5'd11, 5'd0,  6'h25), 1'b0, 32'd0, 1'b0, 32'd7,        1'b0, 2'd3, 5'd0);
    tbl[11] = mk(rtype(6'd0, 5'd3, 5'd4, 5'd13, 5'd5,  6'h20), 1'b0, 32'd0, 1'b0, 32'd12,       1'b0, 2'd0, 5'd5);

    // Reset state and regfile sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", {31'd0, instr_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_rs", alu_rs_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      chk($sformatf("sweep_r%0d", a), dbg_data, 32'd0);
    end

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    dbg_addr = 5'd0;
    #1;
    chk("r0_stays_zero", dbg_data, 32'd0);
    dbg_addr = 5'd9;
    #1;
    chk("illegal_no_wb_r9", dbg_data, 32'd0);
    dbg_addr = 5'd10;
    #1;
    chk("illegal_no_wb_r10", dbg_data, 32'd0);

    // Reset while the op sits in EXEC
    @(negedge clk);
    instr = rtype(6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'h20);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("exec_rs_operand", alu_rs_data, 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rexec_done", {31'd0, done}, 32'd0);
    chk("rexec_result", result, 32'd0);
    chk("rexec_zero", {31'd0, zero_flag}, 32'd0);
    chk("rexec_alu_rs", alu_rs_data, 32'd0);
    chk("rexec_alu_funct", {30'd0, alu_funct}, 32'd0);
    chk("rexec_ready_in_rst", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("rexec_done_later", {31'd0, done}, 32'd0);
    dbg_addr = 5'd12;
    #1;
    chk("rexec_no_wb_r12", dbg_data, 32'd0);
    dbg_addr = 5'd1;
    #1;
    chk("rexec_r1_cleared", dbg_data, 32'd0);

    // instr_valid held high: one handshake per four cycles
    @(negedge clk);
    rst_n = 1'b1;
    instr = rtype(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
    instr_valid = 1'b1;
    hs = 0;
    dn = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (instr_ready) hs++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_valid_handshakes", hs, 32'd4);
    chk("held_valid_dones", dn, 32'd4);
    repeat (5) @(negedge clk);
    chk("drain_ready", {31'd0, instr_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
